// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel emits a 50%-duty divided clock plus a one-cycle tick on its rising edge.
// Divisor, enable and restart are written over a shared address/data config bus.
module clk_div_multi #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DIV_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_valid,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_data,
    output logic              c_ready,
    output logic              c_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int unsigned CH_W   = ADDR_W - 2;
    localparam int unsigned NCH_MAX = 1 << CH_W;

    localparam logic [1:0] REG_LO   = 2'd0;
    localparam logic [1:0] REG_HI   = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    logic              accept_c;
    logic [CH_W-1:0]   ch_sel_c;
    logic [1:0]        reg_sel_c;
    logic [NCH_MAX-1:0] ch_ok_c;

    assign accept_c  = c_valid && c_ready;
    assign ch_sel_c  = c_addr[ADDR_W-1:2];
    assign reg_sel_c = c_addr[1:0];

    // Table of which channel slots in the address space are populated.
    for (genvar g = 0; g < NCH_MAX; g++) begin : g_ch_ok
        if (g < NUM_CH) begin : g_present
            assign ch_ok_c[g] = 1'b1;
        end else begin : g_absent
            assign ch_ok_c[g] = 1'b0;
        end
    end

    // Handshake: one accept, then one bubble; flag writes to absent channels or reserved reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_ready <= 1'b1;
            c_err   <= 1'b0;
        end else begin
            c_ready <= !accept_c;
            c_err   <= accept_c && (!ch_ok_c[ch_sel_c] || (reg_sel_c == REG_RSVD));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  div_act;
        logic [CNT_W-1:0]  div_shad;
        logic [DATA_W-1:0] lo_stage;
        logic              en;
        logic              clk_q;
        logic              tick_q;

        logic sel_c;
        logic wr_lo_c;
        logic wr_hi_c;
        logic wr_ctrl_c;
        logic wrap_c;

        assign sel_c     = accept_c && (ch_sel_c == CH_W'(i));
        assign wr_lo_c   = sel_c && (reg_sel_c == REG_LO);
        assign wr_hi_c   = sel_c && (reg_sel_c == REG_HI);
        assign wr_ctrl_c = sel_c && (reg_sel_c == REG_CTRL);
        assign wrap_c    = (cnt == div_act);

        // Config registers: LO is staged so the divisor only moves on the HI write.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lo_stage <= '0;
                div_shad <= CNT_W'(DIV_RST);
                en       <= 1'b1;
            end else begin
                if (wr_lo_c) begin
                    lo_stage <= c_data;
                end
                if (wr_hi_c) begin
                    div_shad <= CNT_W'({c_data, lo_stage});
                end
                if (wr_ctrl_c) begin
                    en <= c_data[0];
                end
            end
        end

        // Counter and output phase: divisor only commits at a wrap, restart or while idle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                div_act <= CNT_W'(DIV_RST);
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (!en || (wr_ctrl_c && !c_data[0])) begin
                cnt     <= '0;
                div_act <= div_shad;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (wr_ctrl_c && c_data[1]) begin
                cnt     <= '0;
                div_act <= div_shad;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (wrap_c) begin
                cnt     <= '0;
                div_act <= div_shad;
                clk_q   <= !clk_q;
                tick_q  <= !clk_q;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick_q  <= 1'b0;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
    end

endmodule
